// File: rtl/aes_pkg.sv
// Shared definitions for the byte-serial AES control path: state encoding,
// legal key-size bytes and the Nk -> Nr relation.
package aes_pkg;

  localparam int BLOCK_BYTES = 16;

  localparam logic [7:0] KEY128 = 8'd16;
  localparam logic [7:0] KEY192 = 8'd24;
  localparam logic [7:0] KEY256 = 8'd32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_DATA,
    ST_RD_KSIZE,
    ST_RD_KEY,
    ST_KEY_EXP,
    ST_ROUND,
    ST_DONE
  } state_e;

  // Nk of 4/6/8 words gives Nr of 10/12/14; never exceeds 4 bits.
  function automatic logic [3:0] NR_FROM_NK(input logic [3:0] nkWords);
    return nkWords + 4'd6;
  endfunction

  function automatic logic isKeySize(input logic [7:0] sizeByte);
    return (sizeByte == KEY128) || (sizeByte == KEY192) || (sizeByte == KEY256);
  endfunction

endpackage

// File: rtl/aes_round_sequencer.sv
// Control FSM for the byte-serial AES engine: collects block, key size and key
// bytes from the host, then sequences key expansion and the Nr+1 rounds.
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int IDX_W = 5,
  parameter int RND_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_byte,
  output logic             in_ready,
  input  logic             abort,
  output logic             blk_ld,
  output logic             key_ld,
  output logic [IDX_W-1:0] ld_idx,
  output logic [3:0]       nk,
  output logic             ks_start,
  input  logic             ks_done,
  output logic             rnd_start,
  output logic [RND_W-1:0] rnd_idx,
  output logic             rnd_final,
  input  logic             rnd_done,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [3:0]       nk_q, nk_d;
  logic [RND_W-1:0] rndIdx_q, rndIdx_d;
  logic             ksStart_q, ksStart_d;
  logic             rndStart_q, rndStart_d;
  logic             rndFinal_q, rndFinal_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;

  logic             readState;
  logic             accept;
  logic [IDX_W-1:0] keyLastIdx;
  logic [3:0]       nrCur;
  logic [3:0]       nrNext;

  assign readState  = (state_q == ST_RD_DATA) || (state_q == ST_RD_KSIZE) ||
                      (state_q == ST_RD_KEY);
  assign in_ready   = readState && !abort;
  assign accept     = in_valid && in_ready;
  assign blk_ld     = accept && (state_q == ST_RD_DATA);
  assign key_ld     = accept && (state_q == ST_RD_KEY);
  assign ld_idx     = cnt_q;
  assign keyLastIdx = IDX_W'({nk_q, 2'b00} - 6'd1);
  assign nrCur      = NR_FROM_NK(nk_q);
  assign nrNext     = NR_FROM_NK(nk_d);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    nk_d       = nk_q;
    rndIdx_d   = rndIdx_q;
    ksStart_d  = 1'b0;
    rndStart_d = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // The byte that wakes us up is left on the bus for RD_DATA to take.
        if (in_valid) begin
          state_d = ST_RD_DATA;
          cnt_d   = '0;
        end
      end
      ST_RD_DATA: begin
        if (accept) begin
          if (cnt_q == IDX_W'(BLOCK_BYTES - 1)) begin
            state_d = ST_RD_KSIZE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + IDX_W'(1);
          end
        end
      end
      ST_RD_KSIZE: begin
        if (accept) begin
          if (isKeySize(in_byte)) begin
            nk_d    = in_byte[5:2];
            state_d = ST_RD_KEY;
            cnt_d   = '0;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_RD_KEY: begin
        if (accept) begin
          if (cnt_q == keyLastIdx) begin
            state_d   = ST_KEY_EXP;
            ksStart_d = 1'b1;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + IDX_W'(1);
          end
        end
      end
      ST_KEY_EXP: begin
        if (!ksStart_q && ks_done) begin
          state_d    = ST_ROUND;
          rndIdx_d   = '0;
          rndStart_d = 1'b1;
        end
      end
      ST_ROUND: begin
        // A completion arriving alongside the start strobe belongs to nothing.
        if (!rndStart_q && rnd_done) begin
          if (rndIdx_q == RND_W'(nrCur)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            rndIdx_d   = rndIdx_q + RND_W'(1);
            rndStart_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort) begin
      state_d    = ST_IDLE;
      ksStart_d  = 1'b0;
      rndStart_d = 1'b0;
      done_d     = 1'b0;
      err_d      = 1'b0;
    end

    if (state_d == ST_IDLE) begin
      cnt_d    = '0;
      nk_d     = '0;
      rndIdx_d = '0;
    end

    rndFinal_d = (state_d == ST_ROUND) && (rndIdx_d == RND_W'(nrNext));
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      nk_q       <= '0;
      rndIdx_q   <= '0;
      ksStart_q  <= 1'b0;
      rndStart_q <= 1'b0;
      rndFinal_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      nk_q       <= nk_d;
      rndIdx_q   <= rndIdx_d;
      ksStart_q  <= ksStart_d;
      rndStart_q <= rndStart_d;
      rndFinal_q <= rndFinal_d;
      done_q     <= done_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign nk        = nk_q;
  assign ks_start  = ksStart_q;
  assign rnd_start = rndStart_q;
  assign rnd_idx   = rndIdx_q;
  assign rnd_final = rndFinal_q;
  assign done      = done_q;
  assign err       = err_q;
  assign busy      = busy_q;

endmodule
